// File: rtl/wb_sched.sv
// Writeback scheduler and register scoreboard for the S1 decode stage: shares the
// single register-file write port between ALU and load writeback and stalls decode on hazards.
module wb_sched #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    input  logic              dec_valid,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic [4:0]        dec_rd,
    input  logic              dec_rd_we,
    output logic              dec_stall,
    input  logic              alu_wb_valid,
    input  logic [4:0]        alu_wb_rd,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              mem_wb_valid,
    input  logic [4:0]        mem_wb_rd,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic              mem_wb_ready,
    output logic              reg_we,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] reg_din,
    output logic [31:0]       pending
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic              buf_full;
    logic [4:0]        buf_rd;
    logic [DATA_W-1:0] buf_data;
    logic [CNT_W-1:0]  starve_cnt;

    logic              force_bubble;
    logic              hazard;
    logic              issue;
    logic              port_valid;
    logic [4:0]        port_rd;
    logic [DATA_W-1:0] port_data;
    logic              mem_accept;
    logic              buf_fill;
    logic              buf_drain;
    logic [31:0]       set_mask;
    logic [31:0]       clr_mask;

    assign force_bubble = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign hazard       = dec_valid & (pending[dec_rs1] | pending[dec_rs2] |
                                       (dec_rd_we & pending[dec_rd]));
    // No commit bypass: a dependent instruction waits for the registered clear.
    assign dec_stall    = hazard | force_bubble | ~clk_en;
    assign issue        = dec_valid & ~dec_stall & clk_en;

    assign mem_wb_ready = clk_en & ~buf_full;
    assign mem_accept   = mem_wb_valid & mem_wb_ready;
    assign buf_fill     = mem_accept & alu_wb_valid;
    assign buf_drain    = clk_en & buf_full & ~alu_wb_valid;

    // Fixed priority: ALU cannot be back-pressured, so the held load yields to it.
    always_comb begin
        port_valid = 1'b0;
        port_rd    = '0;
        port_data  = '0;
        if (clk_en && async_rst_n) begin
            if (alu_wb_valid) begin
                port_valid = 1'b1;
                port_rd    = alu_wb_rd;
                port_data  = alu_wb_data;
            end else if (buf_full) begin
                port_valid = 1'b1;
                port_rd    = buf_rd;
                port_data  = buf_data;
            end else if (mem_wb_valid) begin
                port_valid = 1'b1;
                port_rd    = mem_wb_rd;
                port_data  = mem_wb_data;
            end
        end
    end

    assign reg_we  = port_valid & (port_rd != 5'd0);
    assign rd_addr = port_rd;
    assign reg_din = port_data;

    assign set_mask = (issue && dec_rd_we && dec_rd != 5'd0) ? (32'd1 << dec_rd) : 32'd0;
    assign clr_mask = reg_we ? (32'd1 << rd_addr) : 32'd0;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            pending    <= '0;
            buf_full   <= 1'b0;
            starve_cnt <= '0;
        end else if (clk_en) begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (buf_fill) begin
                buf_full <= 1'b1;
            end else if (buf_drain) begin
                buf_full <= 1'b0;
            end
            if (buf_drain) begin
                starve_cnt <= '0;
            end else if (buf_full && alu_wb_valid && !force_bubble) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && buf_fill) begin
            buf_rd   <= mem_wb_rd;
            buf_data <= mem_wb_data;
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// Randomized and directed checks of wb_sched against a queue-based behavioural model.
module tb_wb_sched;

    localparam int DATA_W = 32;
    localparam int LIM    = 4;

    logic              clk = 1'b0;
    logic              async_rst_n;
    logic              clk_en;
    logic              dec_valid;
    logic [4:0]        dec_rs1, dec_rs2, dec_rd;
    logic              dec_rd_we;
    logic              dec_stall;
    logic              alu_wb_valid;
    logic [4:0]        alu_wb_rd;
    logic [DATA_W-1:0] alu_wb_data;
    logic              mem_wb_valid;
    logic [4:0]        mem_wb_rd;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_ready;
    logic              reg_we;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] reg_din;
    logic [31:0]       pending;

    wb_sched #(.DATA_W(DATA_W), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_stall(dec_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready), .reg_we(reg_we), .rd_addr(rd_addr),
        .reg_din(reg_din), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model state: in-flight set, held loads, starvation age
    logic [31:0] m_pend;
    ent_t        m_q[$];
    int          m_cnt;
    bit          m_acc;
    bit          m_hold;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_q.delete();
        m_cnt  = 0;
        m_hold = 0;
    endtask

    task automatic drv(input bit dv, input int rs1, input int rs2, input int rd, input bit rdwe,
                       input bit av, input int ard, input logic [31:0] ad,
                       input bit mv, input int mrd, input logic [31:0] md, input bit ce);
        dec_valid = dv; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd); dec_rd_we = rdwe;
        alu_wb_valid = av; alu_wb_rd = 5'(ard); alu_wb_data = ad;
        mem_wb_valid = mv; mem_wb_rd = 5'(mrd); mem_wb_data = md; clk_en = ce;
    endtask

    // Check one cycle's outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        logic [31:0]       np;
        logic [4:0]        srd;
        logic [DATA_W-1:0] sd;
        bit                fb, haz, est, erdy, src, ewe, acc;
        int                nc;
        ent_t              e;
        #4;
        fb   = (m_cnt == LIM);
        haz  = dec_valid && (m_pend[dec_rs1] || m_pend[dec_rs2] || (dec_rd_we && m_pend[dec_rd]));
        est  = haz || fb || !clk_en;
        erdy = clk_en && (m_q.size() == 0);
        src = 0; srd = '0; sd = '0;
        if (clk_en) begin
            if (alu_wb_valid) begin
                src = 1; srd = alu_wb_rd; sd = alu_wb_data;
            end else if (m_q.size() != 0) begin
                src = 1; srd = m_q[0].rd; sd = m_q[0].d;
            end else if (mem_wb_valid) begin
                src = 1; srd = mem_wb_rd; sd = mem_wb_data;
            end
        end
        ewe = src && (srd != 5'd0);
        check("dec_stall", 64'(dec_stall), 64'(est));
        check("mem_wb_ready", 64'(mem_wb_ready), 64'(erdy));
        check("reg_we", 64'(reg_we), 64'(ewe));
        check("pending", 64'(pending), 64'(m_pend));
        if (ewe) begin
            check("rd_addr", 64'(rd_addr), 64'(srd));
            check("reg_din", 64'(reg_din), 64'(sd));
        end
        acc   = mem_wb_valid && erdy;
        m_acc = acc;
        np = m_pend;
        nc = m_cnt;
        if (clk_en) begin
            if (ewe) np[srd] = 1'b0;
            if (dec_valid && !est && dec_rd_we && dec_rd != 5'd0) np[dec_rd] = 1'b1;
            if (m_q.size() != 0) begin
                if (!alu_wb_valid) begin
                    void'(m_q.pop_front());
                    nc = 0;
                end else if (nc < LIM) begin
                    nc++;
                end
            end else if (acc && alu_wb_valid) begin
                e.rd = mem_wb_rd;
                e.d  = mem_wb_data;
                m_q.push_back(e);
            end
        end
        m_hold = mem_wb_valid && !acc;
        @(posedge clk);
        #1;
        m_pend = np;
        m_cnt  = nc;
    endtask

    initial begin
        async_rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        #2;
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_ready", 64'(mem_wb_ready), 64'd1);
        check("rst_reg_we", 64'(reg_we), 64'd0);
        check("rst_stall", 64'(dec_stall), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_reg_din", 64'(reg_din), 64'd0);
        async_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW stall on x5, released one cycle after the ALU commit
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(1, 5, 0, 6, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1); step();
        drv(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(0, 0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 1); step();

        // Collision: ALU wins, load is held and written on the next idle cycle
        drv(0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 7, 32'h22, 1); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();

        // Starvation: held load plus a busy ALU forces decode bubbles
        drv(0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 7, 32'h22, 1); step();
        for (int i = 0; i < 6; i++) begin
            drv(1, 1, 2, 9, 1, 1, 10 + i, 32'h100 + i, 0, 0, 0, 1); step();
        end
        drv(1, 1, 2, 9, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(1, 1, 2, 9, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 1); step();

        // x0 is never tracked and never written
        drv(1, 0, 0, 0, 1, 1, 0, 32'h1234, 0, 0, 0, 1); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55, 1); step();

        // Clock enable low freezes everything while a load is offered
        drv(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1); step();
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0, 4, 1, 1, 8, 32'h88, 1, 4, 32'h44, 0); step();
        end
        drv(0, 0, 0, 0, 0, 1, 8, 32'h88, 1, 4, 32'h44, 1); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();

        // Mid-operation asynchronous reset with pending=0x6 and a full buffer
        drv(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 7, 32'h22, 1); step();
        drv(0, 0, 0, 0, 0, 1, 12, 32'hC, 0, 0, 0, 1);
        #1;
        check("pre_rst_pending", 64'(pending), 64'h6);
        check("pre_rst_ready", 64'(mem_wb_ready), 64'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        async_rst_n = 1'b0;
        #1;
        check("arst_pending", 64'(pending), 64'd0);
        check("arst_ready", 64'(mem_wb_ready), 64'd1);
        check("arst_reg_we", 64'(reg_we), 64'd0);
        check("arst_stall", 64'(dec_stall), 64'd0);
        async_rst_n = 1'b1;
        model_reset();
        step();

        // Randomized traffic honouring load hold-until-accepted
        for (int i = 0; i < 400; i++) begin
            clk_en       = ($urandom_range(0, 9) != 0);
            dec_valid    = $urandom_range(0, 1);
            dec_rs1      = 5'($urandom_range(0, 7));
            dec_rs2      = 5'($urandom_range(0, 7));
            dec_rd       = 5'($urandom_range(0, 7));
            dec_rd_we    = $urandom_range(0, 1);
            alu_wb_valid = ($urandom_range(0, 9) < 6);
            alu_wb_rd    = 5'($urandom_range(0, 7));
            alu_wb_data  = $urandom;
            if (!m_hold) begin
                mem_wb_valid = $urandom_range(0, 1);
                mem_wb_rd    = 5'($urandom_range(0, 7));
                mem_wb_data  = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Writeback scheduler and register scoreboard for the S1 decode stage.
- Owns the decode stage's single register-file write port (reg_we/rd_addr/reg_din) and shares it between the ALU writeback path and the memory (load) writeback path.
- Tracks in-flight destination registers and stalls decode on RAW/WAW hazards.
- Injects decode bubbles when a buffered load result is starved of the write port.

Parameters:
- DATA_W, 32, register data width
- STARVE_LIMIT, 4, cycles a buffered memory result may wait before decode bubbles are forced (>=1)

Ports:
- clk  in  1  clock, rising edge
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; state updates only when high
- dec_valid  in  1  decode holds a valid instruction (inverse of decode invalid)
- dec_rs1  in  5  source register 1 of decoding instruction
- dec_rs2  in  5  source register 2
- dec_rd  in  5  destination register
- dec_rd_we  in  1  instruction writes dec_rd
- dec_stall  out  1  hold decode; instruction is not issued this cycle
- alu_wb_valid  in  1  ALU result available this cycle (cannot be back-pressured)
- alu_wb_rd  in  5  ALU destination
- alu_wb_data  in  DATA_W  ALU result
- mem_wb_valid  in  1  load result offered
- mem_wb_rd  in  5  load destination
- mem_wb_data  in  DATA_W  load result
- mem_wb_ready  out  1  load result accepted when valid&ready
- reg_we  out  1  register file write enable to decode stage
- rd_addr  out  5  register file write address
- reg_din  out  DATA_W  register file write data
- pending  out  32  scoreboard, bit i = write to xi in flight

Behaviour:
- Reset (async_rst_n low, any time): pending=0, hold buffer empty, starve counter=0. Combinational outputs then read reg_we=0, mem_wb_ready=1, dec_stall=0 when dec_valid=0, rd_addr=0, reg_din=0.
- clk_en low: no state changes; reg_we=0, mem_wb_ready=0, dec_stall=1.
- Issue: issue = dec_valid & ~dec_stall & clk_en.
- Hazard: hazard = dec_valid & (pending[dec_rs1] | pending[dec_rs2] | (dec_rd_we & pending[dec_rd])). Bits for x0 are ignored (always 0).
- dec_stall = hazard | force_bubble | ~clk_en. It uses registered pending only, with no same-cycle commit bypass, so a dependent instruction issues one cycle after the producer's commit.
- Scoreboard:
  - Set pending[dec_rd] at the edge where issue & dec_rd_we & dec_rd!=0.
  - Clear pending[rd_addr] at the edge where reg_we.
  - WAW stall guarantees set and clear never target the same bit in one cycle. If it happens anyway, set wins.
- Write-port arbitration (combinational select), fixed priority ALU > hold buffer > direct memory:
  - alu_wb_valid: write ALU data.
  - Else buffer full: write buffer contents; buffer empties at the edge.
  - Else mem_wb_valid: write mem data directly.
- Writes with rd=0 still occupy the port cycle but assert reg_we=0.
- mem_wb_ready = clk_en & buffer empty.
  - Accepted load with ALU also valid: load is captured into the 1-entry hold buffer.
  - Accepted load with ALU idle: load is written directly; buffer stays empty.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each cycle the buffer is full and alu_wb_valid=1.
  - Resets to 0 when the buffer drains.
  - force_bubble = (counter==STARVE_LIMIT). Stalling decode drains the ALU pipe, so the buffer reaches the port. force_bubble drops the cycle after drain.
- Latency: a load accepted with the port free commits in the same cycle. A buffered load commits in the first ALU-idle cycle.
- Back-pressure: a new load is refused while the buffer is full. mem_wb_valid/rd/data must hold until accepted.

Test Plan:
- Reset mid-operation: pending=0x0000_0006 and buffer full, pulse async_rst_n low between edges -> pending=0, mem_wb_ready=1, reg_we=0 immediately, with no clock edge required.
- RAW stall: issue rd=5 (pending[5]=1), next cycle dec_rs1=5 -> dec_stall=1. ALU writes x5=0xDEADBEEF -> reg_we=1, rd_addr=5. Next cycle pending[5]=0, dec_stall=0.
- Collision: alu_wb_valid rd=3 data=0x11 and mem_wb_valid rd=7 data=0x22 same cycle -> port writes x3, load buffered, mem_wb_ready=0 next cycle. ALU idle next cycle -> x7=0x22 written, ready=1.
- Starvation: buffer full, alu_wb_valid held high 4 cycles -> dec_stall=1 from the 5th cycle. Drop alu_wb_valid -> buffer written, dec_stall clears the following cycle.
- x0 handling: issue dec_rd=0 with dec_rd_we=1 -> pending stays 0. ALU wb rd=0 -> reg_we=0.
- clk_en low for 3 cycles with mem_wb_valid=1 -> no writes, mem_wb_ready=0, pending unchanged, dec_stall=1.
